jaxa_activity_pio_in: RTL



---
 rtl/jaxa_pio_pkg.sv | 12 +
 rtl/jaxa_sync_vec.sv | 20 ++
 rtl/jaxa_activity_pio_in.sv | 61 ++++++
 3 files changed

// File: rtl/jaxa_pio_pkg.sv
// jaxa_pio_pkg: register map and edge-type encodings shared by the PIO input ports
package jaxa_pio_pkg;
   typedef enum logic [1:0] {
      ADDR_DATA    = 2'd0,
      ADDR_RSVD    = 2'd1,
      ADDR_IRQMASK = 2'd2,
      ADDR_EDGECAP = 2'd3
   } pio_addr_e;
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/jaxa_sync_vec.sv
// jaxa_sync_vec: SYNC_STAGES-deep flop chain bringing an asynchronous vector into clk
module jaxa_sync_vec #(
   parameter int WIDTH       = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] chain [SYNC_STAGES];
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      else begin
         chain[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      end
   assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/jaxa_activity_pio_in.sv
// jaxa_activity_pio_in: Avalon-MM activity input port with sticky edge capture
// and maskable level interrupt; registered read data with 1-cycle latency.
module jaxa_activity_pio_in
   import jaxa_pio_pkg::*;
#(
   parameter int WIDTH       = 1,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);
   logic [WIDTH-1:0] sync_q, prev_q, mask_q, cap_q, edge_v, mask_d, cap_d, wd;
   logic [2:0]       arm_cnt;
   logic [31:0]      rd_d;
   logic             wr, armed, unused_wd;
   jaxa_sync_vec #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (in_port),
      .q       (sync_q)
   );
   assign wr        = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;
   // Held off until sync and prev both reflect post-reset inputs, so static levels never capture
   assign armed     = arm_cnt == ARM_MAX;
   always_comb
      edge_v = EDGE_TYPE == EDGE_RISE ? sync_q & ~prev_q :
               EDGE_TYPE == EDGE_FALL ? ~sync_q & prev_q : sync_q ^ prev_q;
   assign mask_d = wr && address == ADDR_IRQMASK ? wd : mask_q;
   assign cap_d  = (cap_q & ~(wr && address == ADDR_EDGECAP ? wd : '0)) | (armed ? edge_v : '0);
   always_comb
      rd_d = address == ADDR_DATA    ? 32'(sync_q) :
             address == ADDR_IRQMASK ? 32'(mask_q) :
             address == ADDR_EDGECAP ? 32'(cap_q)  : '0;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         prev_q   <= '0;
         arm_cnt  <= '0;
         mask_q   <= '0;
         cap_q    <= '0;
         irq      <= 1'b0;
         readdata <= '0;
      end else begin
         prev_q   <= sync_q;
         arm_cnt  <= armed ? arm_cnt : arm_cnt + 3'd1;
         mask_q   <= mask_d;
         cap_q    <= cap_d;
         irq      <= |(cap_d & mask_d);
         readdata <= rd_d;
      end
endmodule
